// File: rtl/riscv_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_div_unit
//  Purpose  : Iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
//             One quotient bit per clock. Divide-by-zero and signed overflow
//             finish early with the architecturally defined values.
//  Ports    : clk, rst_n (async active-low)
//             start, op[1:0] (funct3[1:0]), dividend, divisor, flush
//             busy (state != IDLE), done (one-cycle pulse), result (registered)
//  Revision : 1.0  initial release
// ============================================================================
module riscv_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] c_min      = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] c_ones     = {WIDTH{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'(WIDTH-1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic [CNT_W-1:0] r_cnt;
    logic             r_is_rem;
    logic             r_qneg;
    logic             r_rneg;
    logic [WIDTH-1:0] r_result;

    // Operand decode at the accepting edge. op[0]=0 selects the signed ops.
    logic             w_accept;
    logic             w_signed;
    logic             w_div0;
    logic             w_ovf;
    logic [WIDTH-1:0] w_dvd_abs;
    logic [WIDTH-1:0] w_dvs_abs;

    assign w_accept  = (r_state == S_IDLE) && start && !flush;
    assign w_signed  = ~op[0];
    assign w_div0    = (divisor == '0);
    assign w_ovf     = w_signed && (dividend == c_min) && (divisor == c_ones);
    assign w_dvd_abs = (w_signed && dividend[WIDTH-1]) ? (~dividend + 1'b1) : dividend;
    assign w_dvs_abs = (w_signed && divisor[WIDTH-1])  ? (~divisor + 1'b1)  : divisor;

    // Restoring step: shift {rem, quo} left one bit, then trial-subtract the
    // divisor on a WIDTH+1 bit remainder. The borrow bit decides the result.
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;

    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_dvs};
    assign w_ge    = ~w_diff[WIDTH];

    // Sign fix-up applied in the FIX cycle.
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;

    assign w_quo_fix = r_qneg ? (~r_quo + 1'b1) : r_quo;
    assign w_rem_fix = r_rneg ? (~r_rem + 1'b1) : r_rem;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and status outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        busy        = (r_state != S_IDLE);
        done        = (r_state == S_DONE);
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (w_div0 || w_ovf) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (flush) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == '0) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                w_state_nxt = flush ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath. result is only written on an early-out accept or in an
    // unflushed FIX cycle, so a flushed operation leaves it untouched.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvs    <= '0;
            r_cnt    <= '0;
            r_is_rem <= 1'b0;
            r_qneg   <= 1'b0;
            r_rneg   <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_is_rem <= op[1];
                        if (w_div0) begin
                            r_result <= op[1] ? dividend : c_ones;
                        end else if (w_ovf) begin
                            r_result <= op[1] ? '0 : c_min;
                        end else begin
                            r_rem  <= '0;
                            r_quo  <= w_dvd_abs;
                            r_dvs  <= w_dvs_abs;
                            r_cnt  <= c_cnt_init;
                            r_qneg <= w_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                            r_rneg <= w_signed && dividend[WIDTH-1];
                        end
                    end
                end
                S_CALC: begin
                    r_rem <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
                    r_quo <= {r_quo[WIDTH-2:0], w_ge};
                    r_cnt <= r_cnt - 1'b1;
                end
                S_FIX: begin
                    if (!flush) begin
                        r_result <= r_is_rem ? w_rem_fix : w_quo_fix;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_riscv_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_riscv_div_unit
//  Purpose  : Self-checking bench for riscv_div_unit: vector table for the
//             arithmetic cases plus directed busy/flush/reset sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_riscv_div_unit;

    localparam int WIDTH = 32;
    localparam int LAT_N = WIDTH + 2;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    int checks = 0;
    int errors = 0;

    riscv_div_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] exp;
        int               lat;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called #1 after a rising edge. Returns the number of edges from the
    // accepting edge to the first cycle with done high (100 on timeout).
    task automatic run_op(input logic [1:0] o, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, output int edges);
        start = 1'b1; op = o; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0; op = 2'($urandom); dividend = $urandom; divisor = $urandom;
        edges = 1;
        while (!done && edges < 100) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    initial begin
        int edges;
        int seen;

        // DIV=00 DIVU=01 REM=10 REMU=11
        vecs[0]  = '{2'b01, 32'd100,       32'd7,         32'd14,        LAT_N};
        vecs[1]  = '{2'b11, 32'd100,       32'd7,         32'd2,         LAT_N};
        vecs[2]  = '{2'b00, 32'hFFFFFF9C,  32'd7,         32'hFFFFFFF2,  LAT_N};
        vecs[3]  = '{2'b10, 32'hFFFFFF9C,  32'd7,         32'hFFFFFFFE,  LAT_N};
        vecs[4]  = '{2'b01, 32'hFFFFFFFF,  32'd2,         32'h7FFFFFFF,  LAT_N};
        vecs[5]  = '{2'b00, 32'h12345678,  32'd0,         32'hFFFFFFFF,  1};
        vecs[6]  = '{2'b10, 32'h12345678,  32'd0,         32'h12345678,  1};
        vecs[7]  = '{2'b01, 32'h12345678,  32'd0,         32'hFFFFFFFF,  1};
        vecs[8]  = '{2'b11, 32'h12345678,  32'd0,         32'h12345678,  1};
        vecs[9]  = '{2'b00, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  1};
        vecs[10] = '{2'b10, 32'h80000000,  32'hFFFFFFFF,  32'h00000000,  1};
        vecs[11] = '{2'b01, 32'h80000000,  32'hFFFFFFFF,  32'h00000000,  LAT_N};
        vecs[12] = '{2'b11, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  LAT_N};
        vecs[13] = '{2'b00, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  LAT_N};
        vecs[14] = '{2'b10, 32'd7,         32'hFFFFFFFE,  32'h00000001,  LAT_N};
        vecs[15] = '{2'b10, 32'hFFFFFFF9,  32'hFFFFFFFE,  32'hFFFFFFFF,  LAT_N};

        rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00;
        dividend = '0; divisor = '0;
        #12;
        check("reset_busy",   {31'd0, busy}, 32'd0);
        check("reset_done",   {31'd0, done}, 32'd0);
        check("reset_result", result,        32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, edges);
            check($sformatf("vec%0d_latency", i), 32'(edges), 32'(vecs[i].lat));
            check($sformatf("vec%0d_result", i), result, vecs[i].exp);
            @(posedge clk); #1;
            check($sformatf("vec%0d_done_pulse", i), {31'd0, done}, 32'd0);
            check($sformatf("vec%0d_idle", i), {31'd0, busy}, 32'd0);
        end

        // start while busy is ignored
        start = 1'b1; op = 2'b01; dividend = 32'd1000; divisor = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        edges = 1;
        while (!done && edges < 100) begin
            if (edges == 5) begin
                check("busy_at_restart", {31'd0, busy}, 32'd1);
                start = 1'b1; op = 2'b11; dividend = 32'd50; divisor = 32'd9;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            edges++;
        end
        start = 1'b0;
        check("busy_ignore_latency", 32'(edges), 32'(LAT_N));
        check("busy_ignore_result",  result,     32'd333);
        @(posedge clk); #1;

        // flush mid-CALC: no done, result held
        start = 1'b1; op = 2'b01; dividend = 32'd1000; divisor = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_done", {31'd0, done}, 32'd0);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) seen++;
            @(posedge clk); #1;
        end
        check("flush_no_done", 32'(seen), 32'd0);
        check("flush_result",  result,    32'd333);

        // flush and start together in IDLE: start not accepted
        start = 1'b1; flush = 1'b1; op = 2'b01; dividend = 32'd9; divisor = 32'd0;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("flush_start_busy", {31'd0, busy}, 32'd0);
        check("flush_start_done", {31'd0, done}, 32'd0);

        // asynchronous reset between edges mid-CALC
        start = 1'b1; op = 2'b01; dividend = 32'd100; divisor = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("areset_busy",   {31'd0, busy}, 32'd0);
        check("areset_done",   {31'd0, done}, 32'd0);
        check("areset_result", result,        32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(2'b01, 32'd100, 32'd7, edges);
        check("post_reset_latency", 32'(edges), 32'(LAT_N));
        check("post_reset_result",  result,     32'd14);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
